// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer with a 2-entry {pc, instr} buffer. A fetched word reaches the head one cycle later.
// When the buffer is full, fetching stalls until instr_ready pops the head. Redirects flush the buffer.
module instr_fetch_ctrl #(
    parameter int BITS = 32,
    parameter int i_addr_bits = 6,
    parameter logic [i_addr_bits-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [i_addr_bits-1:0] redirect_pc,
    output logic [i_addr_bits-3:0] mem_addr,
    input  logic [BITS-1:0]        mem_dout,
    output logic                   instr_valid,
    output logic [BITS-1:0]        instr,
    output logic [i_addr_bits-1:0] instr_pc,
    input  logic                   instr_ready,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED, ERROR} state_t;

    typedef struct packed {
        logic [i_addr_bits-1:0] pc;
        logic [BITS-1:0]        dat;
    } entry_t;

    state_t                 state, state_nxt;
    logic [i_addr_bits-1:0] pc;
    logic [1:0]             count;
    entry_t                 head, tail, new_ent;
    logic                   redir_ok, redir_bad, pop, push;

    always_comb begin
        redir_ok  = redirect_valid && (state != ERROR) && (redirect_pc[1:0] == 2'b00);
        redir_bad = redirect_valid && (state != ERROR) && (redirect_pc[1:0] != 2'b00);
        pop       = (count != 2'd0) && instr_ready;
        push      = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
        new_ent   = {pc, mem_dout};
    end

    // Halt beats start; any redirect overrides halt/start, a misaligned one traps.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !halt) state_nxt = RUN;
            RUN:     if (halt) state_nxt = HALTED;
            HALTED:  if (start && !halt) state_nxt = RUN;
            default: state_nxt = state;
        endcase
        if (redir_bad) begin
            state_nxt = ERROR;
        end else if (redir_ok) begin
            state_nxt = state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            if (redir_ok) begin
                pc <= redirect_pc;
            end else if (push) begin
                pc <= pc + i_addr_bits'(4);
            end

            if (redir_ok || redir_bad) begin
                count <= 2'd0;
            end else begin
                count <= count + {1'b0, push} - {1'b0, pop};
                // head is always the oldest entry; tail only matters when count==2
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) head <= new_ent;
                        else               tail <= new_ent;
                    end
                    2'b01: head <= tail;
                    2'b11: begin
                        if (count == 2'd1) begin
                            head <= new_ent;
                        end else begin
                            head <= tail;
                            tail <= new_ent;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr    = pc[i_addr_bits-1:2];
    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? head.dat : '0;
    assign instr_pc    = instr_valid ? head.pc  : '0;
    assign busy        = (state == RUN);
    assign err         = (state == ERROR);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboarded bench for instr_fetch_ctrl: reference model pushes expected fetches, negedge monitor checks deliveries.
module tb_instr_fetch_ctrl;

    localparam int BITS   = 32;
    localparam int AB     = 6;
    localparam int RST_PC = 0;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_ERR = 3;

    logic            clk = 1'b0;
    logic            reset, start, halt, redirect_valid, instr_ready;
    logic [AB-1:0]   redirect_pc;
    logic [AB-3:0]   mem_addr;
    logic [BITS-1:0] mem_dout, instr;
    logic            instr_valid;
    logic [AB-1:0]   instr_pc;
    logic            busy, err;
    logic [BITS-1:0] mem [16];

    assign mem_dout = mem[mem_addr];
    always #5 clk = ~clk;

    instr_fetch_ctrl #(.BITS(BITS), .i_addr_bits(AB), .RESET_PC(AB'(RST_PC))) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_dout(mem_dout),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .busy(busy), .err(err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: state, pc and the list of fetched-but-undelivered entries.
    typedef struct {
        int              pc;
        logic [BITS-1:0] dat;
    } exp_t;

    int   mst, mpc, mcnt;
    bit   minit = 1'b0;
    exp_t exp_q[$];

    always @(posedge clk) begin
        bit   p, f;
        exp_t e;
        if (reset) begin
            mst = S_IDLE; mpc = RST_PC; mcnt = 0; exp_q.delete(); minit = 1'b1;
        end else if (minit) begin
            if (redirect_valid && mst != S_ERR) begin
                mcnt = 0;
                exp_q.delete();
                if (int'(redirect_pc) % 4 == 0) mpc = int'(redirect_pc);
                else                            mst = S_ERR;
            end else begin
                p = (mcnt > 0) && instr_ready;
                f = (mst == S_RUN) && (mcnt < 2 || p);
                if (f) begin
                    e.pc  = mpc;
                    e.dat = mem[mpc / 4];
                    exp_q.push_back(e);
                    mpc = (mpc + 4) % 64;
                end
                mcnt = mcnt + int'(f) - int'(p);
                if (halt) begin
                    if (mst == S_RUN) mst = S_HALT;
                end else if (start && (mst == S_IDLE || mst == S_HALT)) begin
                    mst = S_RUN;
                end
            end
        end
    end

    // Monitor: status every cycle, and every accepted instruction against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (minit) begin
            check("status", {instr_valid, busy, err, mem_addr},
                  {mcnt != 0, mst == S_RUN, mst == S_ERR, 4'(mpc / 4)});
            if (!instr_valid) check("empty_head", {instr_pc, instr}, '0);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop: unexpected instr %0h pc %0h at %0t", instr, instr_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", 64'(instr_pc), 64'(e.pc));
                    check("instr", 64'(instr), 64'(e.dat));
                end
            end
        end
    end

    task automatic drive(input bit r, input bit s, input bit h, input bit rv,
                         input logic [AB-1:0] rp, input bit rdy);
        reset = r; start = s; halt = h; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        drive(1, 0, 0, 0, '0, 0);
        tick(2);
        check("rst_mem_addr", 64'(mem_addr), 64'(RST_PC / 4));
        check("rst_flags", {instr_valid, busy, err}, 3'b000);

        // Stream
        drive(0, 1, 0, 0, '0, 1);
        tick(1);
        check("run_first", {busy, instr_valid}, 2'b10);
        drive(0, 0, 0, 0, '0, 1);
        tick(1);
        check("stream_pc0", {instr_valid, instr_pc}, {1'b1, 6'h00});
        check("stream_w0", 64'(instr), 64'(mem[0]));
        tick(5);

        // Backpressure
        drive(1, 0, 0, 0, '0, 0);
        tick(1);
        drive(0, 1, 0, 0, '0, 0);
        tick(1);
        drive(0, 0, 0, 0, '0, 0);
        tick(4);
        check("bp_mem_addr", 64'(mem_addr), 64'd2);
        check("bp_head", 64'(instr_pc), 64'd0);
        drive(0, 0, 0, 0, '0, 1);
        tick(4);

        // Aligned redirect with a full buffer
        drive(1, 0, 0, 0, '0, 0);
        tick(1);
        drive(0, 1, 0, 0, '0, 0);
        tick(3);
        drive(0, 0, 0, 1, 6'h24, 1);
        tick(1);
        check("redir_flush", {instr_valid, mem_addr}, {1'b0, 4'h9});
        drive(0, 0, 0, 0, '0, 1);
        tick(1);
        check("redir_head", {instr_valid, instr_pc}, {1'b1, 6'h24});

        // Misaligned redirect traps until reset
        drive(0, 0, 0, 1, 6'h0A, 1);
        tick(1);
        check("mis_flags", {err, busy, instr_valid}, 3'b100);
        drive(0, 1, 0, 0, '0, 1);
        tick(2);
        check("mis_sticky", {err, busy}, 2'b10);

        // Wrap, then halt with start in the same cycle
        drive(1, 0, 0, 0, '0, 0);
        tick(1);
        drive(0, 0, 0, 1, 6'h3C, 0);
        tick(1);
        drive(0, 1, 0, 0, '0, 0);
        tick(1);
        drive(0, 0, 0, 0, '0, 0);
        tick(2);
        check("wrap_mem_addr", 64'(mem_addr), 64'd1);
        check("wrap_head", 64'(instr_pc), 64'h3C);
        drive(0, 1, 1, 0, '0, 0);
        tick(1);
        check("halt_wins", 64'(busy), 64'd0);
        drive(0, 0, 0, 0, '0, 1);
        tick(3);
        check("halt_drained", {instr_valid, mem_addr}, {1'b0, 4'h1});

        // Reset mid-stream with a full buffer
        drive(0, 0, 0, 1, '0, 0);
        tick(1);
        drive(0, 1, 0, 0, '0, 0);
        tick(3);
        drive(1, 0, 0, 0, '0, 0);
        tick(1);
        check("mid_rst", {instr_valid, busy, err, mem_addr, instr_pc, instr}, '0);

        // Random traffic
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            logic [AB-1:0] rp;
            rp = AB'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15) == 0, rp, $urandom_range(0, 1) == 1);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
